// File: rtl/x86_decode_front.sv
// Purpose: byte-serial x86 front-end decoder (prefixes, opcode, ModR/M, SIB, disp, imm) for a subset ISA.
// Latency: an L-byte instruction captured at edge N shows o_valid after edge N+L+1 (one byte per cycle plus a check cycle).
// Backpressure: accepts only in IDLE (o_ready); results hold in DONE until i_exe_ready, then one IDLE bubble.
// Ports: clk/reset (sync, active-high); i_instr/i_instr_len/i_res_valid/o_ready from fetch;
//        o_valid/i_exe_ready to execute; o_* decoded fields, lengths, prefix flags, o_len, o_error.
module x86_decode_front #(
    parameter int MAX_INSTR_WIDTH = 120,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MAX_INSTR_WIDTH-1:0] i_instr,
    input  logic [3:0]                 i_instr_len,
    input  logic                       i_res_valid,
    output logic                       o_ready,
    output logic                       o_valid,
    input  logic                       i_exe_ready,
    output logic [7:0]                 o_opcode,
    output logic [7:0]                 o_modrm,
    output logic [7:0]                 o_sib,
    output logic                       o_has_modrm,
    output logic                       o_has_sib,
    output logic [DATA_WIDTH-1:0]      o_disp,
    output logic [2:0]                 o_disp_len,
    output logic [DATA_WIDTH-1:0]      o_imm,
    output logic [2:0]                 o_imm_len,
    output logic                       o_op16,
    output logic                       o_lock,
    output logic [1:0]                 o_rep,
    output logic [2:0]                 o_seg,
    output logic [3:0]                 o_len,
    output logic                       o_error
);

    localparam int NBYTES = MAX_INSTR_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, FIND, MODRM, SIB, DISP, IMM, DONE} state_t;

    state_t                     state_q, state_d;
    logic [MAX_INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [3:0]                 len_q, len_d;
    logic [3:0]                 ptr_q, ptr_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       valid_q, valid_d;
    logic [7:0]                 opcode_q, opcode_d;
    logic [7:0]                 modrm_q, modrm_d;
    logic [7:0]                 sib_q, sib_d;
    logic                       has_modrm_q, has_modrm_d;
    logic                       has_sib_q, has_sib_d;
    logic [DATA_WIDTH-1:0]      disp_q, disp_d;
    logic [2:0]                 disp_len_q, disp_len_d;
    logic [DATA_WIDTH-1:0]      imm_q, imm_d;
    logic [2:0]                 imm_len_q, imm_len_d;
    logic                       op16_q, op16_d;
    logic                       lock_q, lock_d;
    logic [1:0]                 rep_q, rep_d;
    logic [2:0]                 seg_q, seg_d;
    logic                       error_q, error_d;

    logic [7:0]                 cur_byte;
    logic [2:0]                 dsize;

    // Displacement size from ModR/M mod, with the mod=00 special encoding
    // (rm=101 in ModR/M, base=101 in SIB) meaning a bare disp32.
    function automatic logic [2:0] disp_size(input logic [1:0] mod, input logic special);
        case (mod)
            2'b00:   return special ? 3'd4 : 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Byte at the parse pointer; pointer never reaches NBYTES because it is
    // bounded by the fetch length before any byte is consumed.
    always_comb begin
        cur_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (ptr_q == 4'(k)) begin
                cur_byte = instr_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        modrm_d     = modrm_q;
        sib_d       = sib_q;
        has_modrm_d = has_modrm_q;
        has_sib_d   = has_sib_q;
        disp_d      = disp_q;
        disp_len_d  = disp_len_q;
        imm_d       = imm_q;
        imm_len_d   = imm_len_q;
        op16_d      = op16_q;
        lock_d      = lock_q;
        rep_d       = rep_q;
        seg_d       = seg_q;
        error_d     = error_q;
        dsize       = 3'd0;

        case (state_q)
            IDLE: begin
                if (i_res_valid) begin
                    instr_d     = i_instr;
                    len_d       = i_instr_len;
                    ptr_d       = 4'd0;
                    cnt_d       = 3'd0;
                    opcode_d    = 8'h00;
                    modrm_d     = 8'h00;
                    sib_d       = 8'h00;
                    has_modrm_d = 1'b0;
                    has_sib_d   = 1'b0;
                    disp_d      = '0;
                    disp_len_d  = 3'd0;
                    imm_d       = '0;
                    imm_len_d   = 3'd0;
                    op16_d      = 1'b0;
                    lock_d      = 1'b0;
                    rep_d       = 2'b00;
                    seg_d       = 3'd0;
                    error_d     = 1'b0;
                    state_d     = FIND;
                end
            end

            FIND, MODRM, SIB, DISP, IMM: begin
                if (ptr_q == len_q) begin
                    // Fetch length exhausted while bytes are still required.
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                    case (state_q)
                        FIND: begin
                            case (cur_byte)
                                8'hF0: lock_d = 1'b1;
                                8'hF2: rep_d  = 2'b10;
                                8'hF3: rep_d  = 2'b11;
                                8'h26: seg_d  = 3'd1;
                                8'h2E: seg_d  = 3'd2;
                                8'h36: seg_d  = 3'd3;
                                8'h3E: seg_d  = 3'd4;
                                8'h64: seg_d  = 3'd5;
                                8'h65: seg_d  = 3'd6;
                                8'h66: op16_d = 1'b1;
                                default: begin
                                    opcode_d = cur_byte;
                                    if (cur_byte == 8'h67 || cur_byte == 8'h0F) begin
                                        error_d = 1'b1;
                                        state_d = DONE;
                                    end else if (cur_byte[7:6] == 2'b00) begin
                                        // ALU group: [2:1] selects r/m form, acc,imm form or one-byte op.
                                        case (cur_byte[2:1])
                                            2'b00, 2'b01: state_d = MODRM;
                                            2'b10: begin
                                                cnt_d     = 3'd0;
                                                imm_len_d = cur_byte[0] ? (op16_q ? 3'd2 : 3'd4) : 3'd1;
                                                state_d   = IMM;
                                            end
                                            default: state_d = DONE;
                                        endcase
                                    end else if (cur_byte[7:5] == 3'b010) begin
                                        state_d = DONE;
                                    end else begin
                                        error_d = 1'b1;
                                        state_d = DONE;
                                    end
                                end
                            endcase
                        end

                        MODRM: begin
                            modrm_d     = cur_byte;
                            has_modrm_d = 1'b1;
                            if (cur_byte[7:6] != 2'b11 && cur_byte[2:0] == 3'b100) begin
                                state_d = SIB;
                            end else begin
                                dsize      = disp_size(cur_byte[7:6], cur_byte[2:0] == 3'b101);
                                disp_len_d = dsize;
                                cnt_d      = 3'd0;
                                state_d    = (dsize != 3'd0) ? DISP : DONE;
                            end
                        end

                        SIB: begin
                            sib_d      = cur_byte;
                            has_sib_d  = 1'b1;
                            dsize      = disp_size(modrm_q[7:6], cur_byte[2:0] == 3'b101);
                            disp_len_d = dsize;
                            cnt_d      = 3'd0;
                            state_d    = (dsize != 3'd0) ? DISP : DONE;
                        end

                        DISP: begin
                            if (disp_len_q == 3'd1) begin
                                disp_d = {{(DATA_WIDTH-8){cur_byte[7]}}, cur_byte};
                            end else begin
                                disp_d[{cnt_q[1:0], 3'b000} +: 8] = cur_byte;
                            end
                            cnt_d = cnt_q + 3'd1;
                            if ((cnt_q + 3'd1) == disp_len_q) begin
                                state_d = DONE;
                            end
                        end

                        default: begin // IMM
                            imm_d[{cnt_q[1:0], 3'b000} +: 8] = cur_byte;
                            cnt_d = cnt_q + 3'd1;
                            if ((cnt_q + 3'd1) == imm_len_q) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                end
            end

            default: begin // DONE
                if (!valid_q) begin
                    // First DONE cycle: final length check, then present results.
                    valid_d = 1'b1;
                    if (ptr_q != len_q) begin
                        error_d = 1'b1;
                    end
                end else if (i_exe_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            len_q       <= 4'd0;
            ptr_q       <= 4'd0;
            cnt_q       <= 3'd0;
            valid_q     <= 1'b0;
            opcode_q    <= 8'h00;
            modrm_q     <= 8'h00;
            sib_q       <= 8'h00;
            has_modrm_q <= 1'b0;
            has_sib_q   <= 1'b0;
            disp_q      <= '0;
            disp_len_q  <= 3'd0;
            imm_q       <= '0;
            imm_len_q   <= 3'd0;
            op16_q      <= 1'b0;
            lock_q      <= 1'b0;
            rep_q       <= 2'b00;
            seg_q       <= 3'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            modrm_q     <= modrm_d;
            sib_q       <= sib_d;
            has_modrm_q <= has_modrm_d;
            has_sib_q   <= has_sib_d;
            disp_q      <= disp_d;
            disp_len_q  <= disp_len_d;
            imm_q       <= imm_d;
            imm_len_q   <= imm_len_d;
            op16_q      <= op16_d;
            lock_q      <= lock_d;
            rep_q       <= rep_d;
            seg_q       <= seg_d;
            error_q     <= error_d;
        end
    end

    assign o_ready     = (state_q == IDLE) && !reset;
    assign o_valid     = valid_q;
    assign o_opcode    = opcode_q;
    assign o_modrm     = modrm_q;
    assign o_sib       = sib_q;
    assign o_has_modrm = has_modrm_q;
    assign o_has_sib   = has_sib_q;
    assign o_disp      = disp_q;
    assign o_disp_len  = disp_len_q;
    assign o_imm       = imm_q;
    assign o_imm_len   = imm_len_q;
    assign o_op16      = op16_q;
    assign o_lock      = lock_q;
    assign o_rep       = rep_q;
    assign o_seg       = seg_q;
    assign o_len       = ptr_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_x86_decode_front.sv
// Scoreboard bench for x86_decode_front: directed instruction vectors with
// hand-computed decodes, a latency check, a DONE stall and a mid-parse reset.
module tb_x86_decode_front;

    localparam int W = 120;
    localparam int D = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  i_instr;
    logic [3:0]    i_instr_len;
    logic          i_res_valid;
    logic          o_ready;
    logic          o_valid;
    logic          i_exe_ready;
    logic [7:0]    o_opcode, o_modrm, o_sib;
    logic          o_has_modrm, o_has_sib;
    logic [D-1:0]  o_disp, o_imm;
    logic [2:0]    o_disp_len, o_imm_len;
    logic          o_op16, o_lock;
    logic [1:0]    o_rep;
    logic [2:0]    o_seg;
    logic [3:0]    o_len;
    logic          o_error;

    x86_decode_front #(.MAX_INSTR_WIDTH(W), .DATA_WIDTH(D)) dut (
        .clk(clk), .reset(reset), .i_instr(i_instr), .i_instr_len(i_instr_len),
        .i_res_valid(i_res_valid), .o_ready(o_ready), .o_valid(o_valid),
        .i_exe_ready(i_exe_ready), .o_opcode(o_opcode), .o_modrm(o_modrm),
        .o_sib(o_sib), .o_has_modrm(o_has_modrm), .o_has_sib(o_has_sib),
        .o_disp(o_disp), .o_disp_len(o_disp_len), .o_imm(o_imm),
        .o_imm_len(o_imm_len), .o_op16(o_op16), .o_lock(o_lock), .o_rep(o_rep),
        .o_seg(o_seg), .o_len(o_len), .o_error(o_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  modrm;
        logic [7:0]  sib;
        logic        has_modrm;
        logic        has_sib;
        logic [31:0] disp;
        logic [2:0]  disp_len;
        logic [31:0] imm;
        logic [2:0]  imm_len;
        logic        op16;
        logic        lock;
        logic [1:0]  rep;
        logic [2:0]  seg;
        logic [3:0]  len;
        logic        error;
    } fields_t;

    typedef struct {
        fields_t f;
        int      cap;
        int      lat;
        string   tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic fields_t mkf(
        input logic [7:0] op, input logic [7:0] mr, input logic [7:0] sb_b,
        input logic hm, input logic hs, input logic [31:0] dsp, input logic [2:0] dl,
        input logic [31:0] im, input logic [2:0] il, input logic o16, input logic lk,
        input logic [1:0] rp, input logic [2:0] sg, input logic [3:0] ln, input logic er);
        fields_t f;
        f.opcode = op;   f.modrm = mr;    f.sib = sb_b;
        f.has_modrm = hm; f.has_sib = hs;
        f.disp = dsp;    f.disp_len = dl;
        f.imm = im;      f.imm_len = il;
        f.op16 = o16;    f.lock = lk;     f.rep = rp;   f.seg = sg;
        f.len = ln;      f.error = er;
        return f;
    endfunction

    function automatic fields_t got_f();
        fields_t f;
        f.opcode = o_opcode;   f.modrm = o_modrm;   f.sib = o_sib;
        f.has_modrm = o_has_modrm; f.has_sib = o_has_sib;
        f.disp = o_disp;       f.disp_len = o_disp_len;
        f.imm = o_imm;         f.imm_len = o_imm_len;
        f.op16 = o_op16;       f.lock = o_lock;     f.rep = o_rep;  f.seg = o_seg;
        f.len = o_len;         f.error = o_error;
        return f;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: latency on the rising edge of o_valid, full field compare at handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: got o_valid=1 expected no output");
                end else if (sb[0].lat != 0) begin
                    chk({sb[0].tag, "_latency"}, 128'(cyc), 128'(sb[0].cap + sb[0].lat));
                end
            end
            if (o_valid && i_exe_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_handshake: got output %h expected none", got_f());
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(e.tag, 128'(got_f()), 128'(e.f));
                end
            end
        end
        prev_v = o_valid;
    end

    // Called at #1 after a posedge; returns #1 after the capture edge.
    task automatic issue(input string tag, input logic [55:0] seq, input int nb,
                         input logic [3:0] len, input fields_t exp, input int lat, input bit push);
        int waitc;
        logic [W-1:0] v;
        waitc = 0;
        while (!o_ready && waitc < 60) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!o_ready) begin
            tests++; fails++;
            $display("FAIL %s_ready_timeout: got o_ready=0 expected 1", tag);
            return;
        end
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = seq[8*(nb-1-k) +: 8];
        i_instr = v;
        i_instr_len = len;
        i_res_valid = 1'b1;
        if (push) sb.push_back('{exp, cyc + 1, lat, tag});
        @(posedge clk); #1;
        i_res_valid = 1'b0;
        i_instr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fields_t z;
        int waitc;
        z = '0;
        reset = 1'b1;
        i_instr = '0;
        i_instr_len = 4'd0;
        i_res_valid = 1'b0;
        i_exe_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_fields", 128'(got_f()), 128'(z));
        chk("reset_valid", 128'(o_valid), 128'(0));
        chk("reset_ready", 128'(o_ready), 128'(0));
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 128'(o_ready), 128'(1));
        @(posedge clk); #1;

        issue("add_al_imm8", 56'h047F, 2, 4'd2,
              mkf(8'h04, 0, 0, 0, 0, 0, 0, 32'h7F, 3'd1, 0, 0, 2'b00, 3'd0, 4'd2, 0), 3, 1);
        issue("op16_imm16", 56'h66053412, 4, 4'd4,
              mkf(8'h05, 0, 0, 0, 0, 0, 0, 32'h1234, 3'd2, 1, 0, 2'b00, 3'd0, 4'd4, 0), 5, 1);
        issue("sib_disp8", 56'h014424F8, 4, 4'd4,
              mkf(8'h01, 8'h44, 8'h24, 1, 1, 32'hFFFFFFF8, 3'd1, 0, 0, 0, 0, 2'b00, 3'd0, 4'd4, 0), 5, 1);
        issue("rip_disp32", 56'h03057856341200 >> 8, 6, 4'd6,
              mkf(8'h03, 8'h05, 0, 1, 0, 32'h12345678, 3'd4, 0, 0, 0, 0, 2'b00, 3'd0, 4'd6, 0), 7, 1);
        issue("sib_base101", 56'h03042544332211, 7, 4'd7,
              mkf(8'h03, 8'h04, 8'h25, 1, 1, 32'h11223344, 3'd4, 0, 0, 0, 0, 2'b00, 3'd0, 4'd7, 0), 8, 1);
        issue("disp8_pos", 56'h004005, 3, 4'd3,
              mkf(8'h00, 8'h40, 0, 1, 0, 32'h05, 3'd1, 0, 0, 0, 0, 2'b00, 3'd0, 4'd3, 0), 4, 1);
        issue("prefix_mix", 56'hF0F2F32E6501C0, 7, 4'd7,
              mkf(8'h01, 8'hC0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b11, 3'd6, 4'd7, 0), 8, 1);
        issue("op16_imm8", 56'h6604AB, 3, 4'd3,
              mkf(8'h04, 0, 0, 0, 0, 0, 0, 32'hAB, 3'd1, 1, 0, 2'b00, 3'd0, 4'd3, 0), 4, 1);
        issue("seg_last_wins", 56'h26363E2F, 4, 4'd4,
              mkf(8'h2F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd4, 4'd4, 0), 5, 1);
        issue("err_0f", 56'h0F05, 2, 4'd2,
              mkf(8'h0F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 4'd1, 1), 0, 1);
        issue("err_len_mismatch", 56'h40, 1, 4'd2,
              mkf(8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 4'd1, 1), 0, 1);
        issue("err_trunc_imm32", 56'h0512, 2, 4'd2,
              mkf(8'h05, 0, 0, 0, 0, 0, 0, 32'h12, 3'd4, 0, 0, 2'b00, 3'd0, 4'd2, 1), 0, 1);
        issue("err_bad_opcode", 56'h90, 1, 4'd1,
              mkf(8'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 4'd1, 1), 0, 1);

        // Stall in DONE: results hold, fetch is refused.
        waitc = 0;
        while (!o_ready && waitc < 60) begin @(posedge clk); #1; waitc++; end
        i_exe_ready = 1'b0;
        z = mkf(8'h04, 0, 0, 0, 0, 0, 0, 32'h11, 3'd1, 0, 0, 2'b00, 3'd0, 4'd2, 0);
        issue("stall", 56'h0411, 2, 4'd2, z, 3, 1);
        waitc = 0;
        while (!o_valid && waitc < 40) begin @(posedge clk); #1; waitc++; end
        chk("stall_valid_seen", 128'(o_valid), 128'(1));
        for (int s = 0; s < 3; s++) begin
            i_instr = 120'h90;
            i_instr_len = 4'd1;
            i_res_valid = 1'b1;
            chk("stall_ready_low", 128'(o_ready), 128'(0));
            chk("stall_fields_hold", 128'(got_f()), 128'(z));
            chk("stall_valid_hold", 128'(o_valid), 128'(1));
            @(posedge clk); #1;
        end
        i_res_valid = 1'b0;
        i_instr = '0;
        i_exe_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_back_idle", 128'({o_ready, o_valid}), 128'(2'b10));

        // Reset while in DISP abandons the instruction.
        issue("abandoned", 56'h03057856341200 >> 8, 6, 4'd6, z, 0, 0);
        @(posedge clk); #1;   // FIND -> MODRM
        @(posedge clk); #1;   // MODRM -> DISP
        reset = 1'b1;
        @(posedge clk); #1;
        z = '0;
        chk("midreset_fields", 128'(got_f()), 128'(z));
        chk("midreset_valid_ready", 128'({o_valid, o_ready}), 128'(2'b00));
        reset = 1'b0;
        #1;
        chk("midreset_ready_after", 128'(o_ready), 128'(1));
        @(posedge clk); #1;
        issue("after_reset", 56'h02C8, 2, 4'd2,
              mkf(8'h02, 8'hC8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 4'd2, 0), 3, 1);

        waitc = 0;
        while (sb.size() != 0 && waitc < 100) begin @(posedge clk); #1; waitc++; end
        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
